// File: rtl/bp_me_dev_router_pkg.sv
// Shared types and default address map for the uncached I/O device router.
package bp_me_dev_router_pkg;

    typedef enum logic [2:0] {
        DevBoot  = 3'd0,
        DevHost  = 3'd1,
        DevCfg   = 3'd2,
        DevClint = 3'd3,
        DevCache = 3'd4
    } bp_dev_id_e;

    typedef enum logic {StEmpty, StFull} cmd_state_e;

    localparam int unsigned NumDev         = 5;
    localparam int unsigned PaddrWidth     = 40;
    localparam int unsigned DataWidth      = 64;
    localparam int unsigned MaxOutstanding = 4;

    // Device i occupies slice i; each device owns a 1 MiB window.
    localparam logic [NumDev*PaddrWidth-1:0] DefaultBaseAddr = {
        40'h00_0040_0000, 40'h00_0030_0000, 40'h00_0020_0000,
        40'h00_0010_0000, 40'h00_0000_0000
    };
    localparam logic [NumDev*PaddrWidth-1:0] DefaultAddrMask = {NumDev{40'hFF_FFF0_0000}};
    localparam logic [DataWidth-1:0]         DefaultErrData  = 64'hDEAD_BEEF;

endpackage

// File: rtl/bp_me_dev_router_if.sv
// Command, device and response bundle of the device router.
interface bp_me_dev_router_if
    import bp_me_dev_router_pkg::*;
#(
    parameter int unsigned num_dev_p     = NumDev,
    parameter int unsigned paddr_width_p = PaddrWidth,
    parameter int unsigned data_width_p  = DataWidth
) ();
    logic                              cmd_v_i;
    logic                              cmd_ready_o;
    logic                              cmd_w_i;
    logic [paddr_width_p-1:0]          cmd_addr_i;
    logic [data_width_p-1:0]           cmd_data_i;
    logic [num_dev_p-1:0]              dev_cmd_v_o;
    logic [num_dev_p-1:0]              dev_cmd_ready_i;
    logic                              dev_cmd_w_o;
    logic [paddr_width_p-1:0]          dev_cmd_addr_o;
    logic [data_width_p-1:0]           dev_cmd_data_o;
    logic [num_dev_p-1:0]              dev_resp_v_i;
    logic [num_dev_p*data_width_p-1:0] dev_resp_data_i;
    logic [num_dev_p-1:0]              dev_resp_yumi_o;
    logic                              resp_v_o;
    logic [data_width_p-1:0]           resp_data_o;
    logic                              resp_err_o;
    logic                              resp_yumi_i;
    logic [7:0]                        err_cnt_o;

    modport slave (
        input  cmd_v_i, cmd_w_i, cmd_addr_i, cmd_data_i, dev_cmd_ready_i,
               dev_resp_v_i, dev_resp_data_i, resp_yumi_i,
        output cmd_ready_o, dev_cmd_v_o, dev_cmd_w_o, dev_cmd_addr_o, dev_cmd_data_o,
               dev_resp_yumi_o, resp_v_o, resp_data_o, resp_err_o, err_cnt_o
    );

    modport master (
        output cmd_v_i, cmd_w_i, cmd_addr_i, cmd_data_i, dev_cmd_ready_i,
               dev_resp_v_i, dev_resp_data_i, resp_yumi_i,
        input  cmd_ready_o, dev_cmd_v_o, dev_cmd_w_o, dev_cmd_addr_o, dev_cmd_data_o,
               dev_resp_yumi_o, resp_v_o, resp_data_o, resp_err_o, err_cnt_o
    );
endinterface

// File: rtl/bp_me_dev_router_order_fifo.sv
// Issue-order queue of device tags; power-of-two depth so pointers wrap naturally.
module bp_me_dev_router_order_fifo #(
    parameter int unsigned width_p = 4,
    parameter int unsigned els_p   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [width_p-1:0] wdata,
    output logic               full,
    input  logic               pop,
    output logic [width_p-1:0] rdata,
    output logic               empty
);
    localparam int unsigned PtrWidth = $clog2(els_p);
    localparam int unsigned CntWidth = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_q [els_p];
    logic [PtrWidth-1:0] wptr_q, rptr_q;
    logic [CntWidth-1:0] cnt_q;
    logic                do_push, do_pop;

    assign full    = (cnt_q == CntWidth'(els_p));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PtrWidth'(1);
            if (do_pop)  rptr_q <= rptr_q + PtrWidth'(1);
            cnt_q <= cnt_q + CntWidth'(do_push) - CntWidth'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end
endmodule

// File: rtl/bp_me_dev_router.sv
// N-device address router: one command stage, in-order responses, internal error replies.
module bp_me_dev_router
    import bp_me_dev_router_pkg::*;
#(
    parameter int unsigned                           num_dev_p         = NumDev,
    parameter int unsigned                           paddr_width_p     = PaddrWidth,
    parameter int unsigned                           data_width_p      = DataWidth,
    parameter int unsigned                           max_outstanding_p = MaxOutstanding,
    parameter logic [num_dev_p*paddr_width_p-1:0]    dev_base_addr_p   = DefaultBaseAddr,
    parameter logic [num_dev_p*paddr_width_p-1:0]    dev_addr_mask_p   = DefaultAddrMask,
    parameter logic [data_width_p-1:0]               err_data_p        = DefaultErrData
) (
    input logic                clk_i,
    input logic                reset_n_i,
    bp_me_dev_router_if.slave  bus
);
    localparam int unsigned IdWidth  = (num_dev_p > 1) ? $clog2(num_dev_p) : 1;
    localparam int unsigned TagWidth = IdWidth + 1;

    cmd_state_e               state_q, state_d;
    logic [IdWidth-1:0]       dev_q, hit_id;
    logic                     w_q, hit, drain, cmd_ready, accept, load, pop;
    logic [paddr_width_p-1:0] addr_q;
    logic [data_width_p-1:0]  data_q;
    logic [7:0]               err_cnt_q;
    logic                     fifo_full, fifo_empty;
    logic [TagWidth-1:0]      head;
    logic [num_dev_p-1:0]     dev_cmd_v, dev_resp_yumi;
    logic                     resp_v, resp_err;
    logic [data_width_p-1:0]  resp_data;

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        hit    = 1'b0;
        hit_id = '0;
        for (int i = num_dev_p - 1; i >= 0; i--) begin
            if ((bus.cmd_addr_i & dev_addr_mask_p[i*paddr_width_p +: paddr_width_p]) ==
                (dev_base_addr_p[i*paddr_width_p +: paddr_width_p] &
                 dev_addr_mask_p[i*paddr_width_p +: paddr_width_p])) begin
                hit    = 1'b1;
                hit_id = IdWidth'(i);
            end
        end
    end

    assign drain     = (state_q == StFull) && bus.dev_cmd_ready_i[dev_q];
    assign cmd_ready = reset_n_i && ((state_q == StEmpty) || drain) && !fifo_full;
    assign accept    = bus.cmd_v_i && cmd_ready;
    assign load      = accept && hit;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = StFull;
        end else if (drain) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= StEmpty;
            dev_q     <= '0;
            w_q       <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                dev_q  <= hit_id;
                w_q    <= bus.cmd_w_i;
                addr_q <= bus.cmd_addr_i;
                data_q <= bus.cmd_data_i;
            end
            if (accept && !hit && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    bp_me_dev_router_order_fifo #(
        .width_p (TagWidth),
        .els_p   (max_outstanding_p)
    ) u_order_fifo (
        .clk   (clk_i),
        .rst_n (reset_n_i),
        .push  (accept),
        .wdata ({~hit, hit_id}),
        .full  (fifo_full),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty)
    );

    // Only the queue head may be yumi'd; other devices keep their responses pending.
    always_comb begin
        dev_cmd_v     = '0;
        resp_v        = 1'b0;
        resp_data     = '0;
        resp_err      = 1'b0;
        dev_resp_yumi = '0;
        if (state_q == StFull) dev_cmd_v[dev_q] = 1'b1;
        if (!fifo_empty) begin
            if (head[TagWidth-1]) begin
                resp_v    = 1'b1;
                resp_data = err_data_p;
                resp_err  = 1'b1;
            end else begin
                for (int i = 0; i < num_dev_p; i++) begin
                    if (head[IdWidth-1:0] == IdWidth'(i)) begin
                        resp_v           = bus.dev_resp_v_i[i];
                        resp_data        = bus.dev_resp_data_i[i*data_width_p +: data_width_p];
                        dev_resp_yumi[i] = bus.resp_yumi_i & bus.dev_resp_v_i[i];
                    end
                end
            end
        end
    end

    assign pop                 = resp_v && bus.resp_yumi_i;
    assign bus.cmd_ready_o     = cmd_ready;
    assign bus.dev_cmd_v_o     = dev_cmd_v;
    assign bus.dev_cmd_w_o     = w_q;
    assign bus.dev_cmd_addr_o  = addr_q;
    assign bus.dev_cmd_data_o  = data_q;
    assign bus.dev_resp_yumi_o = dev_resp_yumi;
    assign bus.resp_v_o        = resp_v;
    assign bus.resp_data_o     = resp_data;
    assign bus.resp_err_o      = resp_err;
    assign bus.err_cnt_o       = err_cnt_q;
endmodule

// File: tb/tb_bp_me_dev_router.sv
// Directed bench for bp_me_dev_router with an address-map/queue reference model.
module tb_bp_me_dev_router;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bp_me_dev_router_if #(.num_dev_p(5), .paddr_width_p(40), .data_width_p(64)) bus ();

    bp_me_dev_router #(
        .num_dev_p         (5),
        .paddr_width_p     (40),
        .data_width_p      (64),
        .max_outstanding_p (4)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: address map, pending device command, FIFO of tags (-1 = error).
    localparam logic [39:0] Mask = 40'hFF_FFF0_0000;
    logic [39:0] base_tab [5] = '{40'h0, 40'h10_0000, 40'h20_0000, 40'h30_0000, 40'h40_0000};
    bit          m_pend = 1'b0;
    int          m_pend_dev = 0;
    logic        m_pend_w = 1'b0;
    logic [39:0] m_pend_addr = '0;
    logic [63:0] m_pend_data = '0;
    int          m_q[$];
    int          m_err = 0;

    function automatic int decode(input logic [39:0] a);
        for (int i = 0; i < 5; i++) if ((a & Mask) == (base_tab[i] & Mask)) return i;
        return -1;
    endfunction

    function automatic void predict(output bit rdy, output logic [4:0] dv, output bit rv,
                                    output logic [63:0] rd, output bit re, output logic [4:0] ry);
        int h;
        rdy = rst_n && (!m_pend || bus.dev_cmd_ready_i[m_pend_dev]) && (m_q.size() < 4);
        dv = '0;
        if (m_pend) dv[m_pend_dev] = 1'b1;
        rv = 1'b0; rd = '0; re = 1'b0; ry = '0;
        if (m_q.size() != 0) begin
            h = m_q[0];
            if (h < 0) begin
                rv = 1'b1; rd = 64'hDEAD_BEEF; re = 1'b1;
            end else begin
                rv = bus.dev_resp_v_i[h];
                rd = bus.dev_resp_data_i[h*64 +: 64];
                ry[h] = bus.resp_yumi_i & bus.dev_resp_v_i[h];
            end
        end
    endfunction

    bit          u_rdy, u_rv, u_re;
    logic [4:0]  u_dv, u_ry;
    logic [63:0] u_rd;
    int          u_d;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 1'b0;
            m_q.delete();
            m_err = 0;
        end else begin
            predict(u_rdy, u_dv, u_rv, u_rd, u_re, u_ry);
            if (u_rv && bus.resp_yumi_i) void'(m_q.pop_front());
            if (m_pend && bus.dev_cmd_ready_i[m_pend_dev]) m_pend = 1'b0;
            if (bus.cmd_v_i && u_rdy) begin
                u_d = decode(bus.cmd_addr_i);
                m_q.push_back(u_d);
                if (u_d >= 0) begin
                    m_pend = 1'b1; m_pend_dev = u_d; m_pend_w = bus.cmd_w_i;
                    m_pend_addr = bus.cmd_addr_i; m_pend_data = bus.cmd_data_i;
                end else if (m_err < 255) begin
                    m_err++;
                end
            end
        end
    end

    bit          c_rdy, c_rv, c_re;
    logic [4:0]  c_dv, c_ry;
    logic [63:0] c_rd;
    always @(negedge clk) begin
        predict(c_rdy, c_dv, c_rv, c_rd, c_re, c_ry);
        chk("cmd_ready", bus.cmd_ready_o, c_rdy);
        chk("dev_cmd_v", bus.dev_cmd_v_o, c_dv);
        if (m_pend) begin
            chk("dev_cmd_w", bus.dev_cmd_w_o, m_pend_w);
            chk("dev_cmd_addr", bus.dev_cmd_addr_o, m_pend_addr);
            chk("dev_cmd_data", bus.dev_cmd_data_o, m_pend_data);
        end
        chk("resp_v", bus.resp_v_o, c_rv);
        if (c_rv) begin
            chk("resp_data", bus.resp_data_o, c_rd);
            chk("resp_err", bus.resp_err_o, c_re);
        end
        chk("dev_resp_yumi", bus.dev_resp_yumi_o, c_ry);
        chk("err_cnt", bus.err_cnt_o, 64'(m_err));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.cmd_v_i = 1'b0; bus.cmd_w_i = 1'b0; bus.cmd_addr_i = '0; bus.cmd_data_i = '0;
        bus.dev_cmd_ready_i = '0; bus.dev_resp_v_i = '0; bus.dev_resp_data_i = '0;
        bus.resp_yumi_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.cmd_ready_o, 0);
        chk("rst_err_cnt", bus.err_cnt_o, 0);
        rst_n = 1'b1;
        #1 chk("release_ready", bus.cmd_ready_o, 1);

        // Load to host (dev1) and its response.
        bus.cmd_v_i = 1'b1; bus.cmd_addr_i = 40'h10_0000;
        step();
        bus.cmd_v_i = 1'b0;
        #1 chk("a_dev_cmd_v", bus.dev_cmd_v_o, 5'b00010);
        chk("a_dev_cmd_addr", bus.dev_cmd_addr_o, 40'h10_0000);
        bus.dev_cmd_ready_i = 5'b00010;
        step();
        bus.dev_cmd_ready_i = '0;
        bus.dev_resp_v_i = 5'b00010; bus.dev_resp_data_i[64 +: 64] = 64'h1234;
        #1 chk("a_resp_v", bus.resp_v_o, 1);
        chk("a_resp_data", bus.resp_data_o, 64'h1234);
        chk("a_resp_err", bus.resp_err_o, 0);
        bus.resp_yumi_i = 1'b1;
        #1 chk("a_yumi", bus.dev_resp_yumi_o, 5'b00010);
        step();
        bus.dev_resp_v_i = '0; bus.resp_yumi_i = 1'b0;
        #1 chk("a_resp_done", bus.resp_v_o, 0);

        // Store to clint, then an unmapped load.
        bus.cmd_v_i = 1'b1; bus.cmd_w_i = 1'b1; bus.cmd_addr_i = 40'h30_BFF8;
        bus.cmd_data_i = 64'hAA55;
        step();
        bus.cmd_v_i = 1'b0;
        #1 chk("b_dev_cmd_v", bus.dev_cmd_v_o, 5'b01000);
        chk("b_dev_cmd_w", bus.dev_cmd_w_o, 1);
        chk("b_dev_cmd_data", bus.dev_cmd_data_o, 64'hAA55);
        bus.dev_cmd_ready_i = 5'b01000;
        step();
        bus.dev_cmd_ready_i = '0; bus.dev_resp_v_i = 5'b01000; bus.resp_yumi_i = 1'b1;
        step();
        bus.dev_resp_v_i = '0; bus.resp_yumi_i = 1'b0;
        bus.cmd_v_i = 1'b1; bus.cmd_w_i = 1'b0; bus.cmd_addr_i = 40'h50_0000;
        step();
        bus.cmd_v_i = 1'b0;
        #1 chk("b_err_no_dev_cmd", bus.dev_cmd_v_o, 0);
        chk("b_err_resp_v", bus.resp_v_o, 1);
        chk("b_err_resp_err", bus.resp_err_o, 1);
        chk("b_err_resp_data", bus.resp_data_o, 64'hDEAD_BEEF);
        chk("b_err_cnt", bus.err_cnt_o, 1);
        bus.resp_yumi_i = 1'b1;
        step();
        bus.resp_yumi_i = 1'b0;
        #1 chk("b_err_popped", bus.resp_v_o, 0);

        // dev4 then dev0; dev0 answers first and must wait.
        bus.cmd_v_i = 1'b1; bus.cmd_addr_i = 40'h40_0000;
        step();
        bus.cmd_addr_i = 40'h0; bus.dev_cmd_ready_i = 5'b10000;
        #1 chk("c_ready_on_drain", bus.cmd_ready_o, 1);
        step();
        bus.cmd_v_i = 1'b0; bus.dev_cmd_ready_i = 5'b00001;
        #1 chk("c_dev0_cmd_v", bus.dev_cmd_v_o, 5'b00001);
        step();
        bus.dev_cmd_ready_i = '0;
        bus.dev_resp_v_i = 5'b00001; bus.dev_resp_data_i[0 +: 64] = 64'hD0;
        bus.resp_yumi_i = 1'b1;
        #1 chk("c_blocked_resp_v", bus.resp_v_o, 0);
        chk("c_blocked_yumi", bus.dev_resp_yumi_o, 0);
        step();
        bus.dev_resp_v_i = 5'b10001; bus.dev_resp_data_i[256 +: 64] = 64'hD4;
        #1 chk("c_first_data", bus.resp_data_o, 64'hD4);
        chk("c_first_yumi", bus.dev_resp_yumi_o, 5'b10000);
        step();
        bus.dev_resp_v_i = 5'b00001;
        #1 chk("c_second_data", bus.resp_data_o, 64'hD0);
        chk("c_second_yumi", bus.dev_resp_yumi_o, 5'b00001);
        step();
        bus.dev_resp_v_i = '0; bus.resp_yumi_i = 1'b0;

        // Fill the order queue; a same-cycle pop must not reopen acceptance.
        bus.dev_cmd_ready_i = 5'b11111; bus.cmd_v_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.cmd_addr_i = 40'h20_0000 + 40'(k * 8);
            step();
        end
        #1 chk("d_full_ready", bus.cmd_ready_o, 0);
        bus.dev_resp_v_i = 5'b00100; bus.resp_yumi_i = 1'b1;
        #1 chk("d_full_pop_ready", bus.cmd_ready_o, 0);
        step();
        bus.dev_resp_v_i = '0; bus.resp_yumi_i = 1'b0;
        #1 chk("d_ready_after_pop", bus.cmd_ready_o, 1);
        bus.cmd_v_i = 1'b0;
        bus.dev_resp_v_i = 5'b00100; bus.resp_yumi_i = 1'b1;
        repeat (3) step();
        bus.dev_resp_v_i = '0; bus.resp_yumi_i = 1'b0; bus.dev_cmd_ready_i = '0;

        // Error counter saturation.
        bus.cmd_v_i = 1'b1; bus.cmd_addr_i = 40'h50_0000; bus.resp_yumi_i = 1'b1;
        repeat (300) step();
        bus.cmd_v_i = 1'b0;
        step();
        bus.resp_yumi_i = 1'b0;
        #1 chk("e_err_sat", bus.err_cnt_o, 8'hFF);
        chk("e_queue_empty", bus.resp_v_o, 0);

        // Reset with three commands outstanding.
        bus.dev_cmd_ready_i = 5'b11111; bus.cmd_v_i = 1'b1; bus.cmd_addr_i = 40'h10_0000;
        repeat (3) step();
        bus.cmd_v_i = 1'b0; bus.dev_cmd_ready_i = '0;
        bus.dev_resp_v_i = 5'b00010; bus.dev_resp_data_i[64 +: 64] = 64'h77;
        #1 chk("f_pre_dev_cmd_v", bus.dev_cmd_v_o, 5'b00010);
        chk("f_pre_resp_v", bus.resp_v_o, 1);
        rst_n = 1'b0;
        #1 chk("f_rst_dev_cmd_v", bus.dev_cmd_v_o, 0);
        chk("f_rst_resp_v", bus.resp_v_o, 0);
        chk("f_rst_ready", bus.cmd_ready_o, 0);
        chk("f_rst_err_cnt", bus.err_cnt_o, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("f_late_resp_ignored", bus.resp_v_o, 0);
        chk("f_rel_ready", bus.cmd_ready_o, 1);
        bus.dev_resp_v_i = '0;
        bus.cmd_v_i = 1'b1; bus.cmd_addr_i = 40'h30_0000;
        step();
        bus.cmd_v_i = 1'b0;
        #1 chk("f_new_dev_cmd_v", bus.dev_cmd_v_o, 5'b01000);
        bus.dev_cmd_ready_i = 5'b01000;
        step();
        bus.dev_cmd_ready_i = '0;
        bus.dev_resp_v_i = 5'b01000; bus.dev_resp_data_i[192 +: 64] = 64'h99;
        #1 chk("f_new_resp_data", bus.resp_data_o, 64'h99);
        bus.resp_yumi_i = 1'b1;
        step();
        bus.dev_resp_v_i = '0; bus.resp_yumi_i = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
